// File: rtl/sb_cfg_pkg.sv
// Shared constants, block table, FSM states and address mapping
// for the sb_1__3_ configuration loader.
package sb_cfg_pkg;

    localparam int NUM_BLOCKS = 15;
    localparam int ADDR_W     = 7;
    localparam int TOTAL_BITS = 54;
    localparam int BLK_W      = 4;
    localparam int BIT_W      = 3;
    localparam int CNT_W      = 6;

    localparam logic [BIT_W-1:0] BITS_PER_BLOCK [NUM_BLOCKS] = '{
        3'd6, 3'd6, 3'd6, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2,
        3'd2, 3'd2, 3'd2, 3'd2, 3'd6, 3'd6, 3'd6
    };

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BIT,
        SETUP,
        STROBE,
        DONE
    } state_e;

    // address[0] is the MSB; 2-bit blocks only use address[0] for the bit
    function automatic logic [0:ADDR_W-1] cfg_addr(
        input logic [BLK_W-1:0] blk,
        input logic [BIT_W-1:0] bit_idx
    );
        logic [0:ADDR_W-1] a;
        a      = '0;
        a[3:6] = blk;
        if (BITS_PER_BLOCK[blk] == 3'd6) begin
            a[0:2] = bit_idx;
        end else begin
            a[0] = bit_idx[0];
        end
        return a;
    endfunction

endpackage

// File: rtl/sb_cfg_addr_counter.sv
// Block/bit walker: steps through each block's bits, then to the
// next block, wrapping to block 0 after the last block.
module sb_cfg_addr_counter
    import sb_cfg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             adv,
    output logic [BLK_W-1:0] blk,
    output logic [BIT_W-1:0] bit_idx
);

    logic [BLK_W-1:0] blk_q, blk_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             last_bit;

    always_comb begin
        blk_d    = blk_q;
        bit_d    = bit_q;
        last_bit = (bit_q == BITS_PER_BLOCK[blk_q] - 3'd1);
        if (clr) begin
            blk_d = '0;
            bit_d = '0;
        end else if (adv) begin
            if (last_bit) begin
                bit_d = '0;
                blk_d = (blk_q == BLK_W'(NUM_BLOCKS - 1)) ? '0 : blk_q + BLK_W'(1);
            end else begin
                bit_d = bit_q + BIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_q <= '0;
            bit_q <= '0;
        end else begin
            blk_q <= blk_d;
            bit_q <= bit_d;
        end
    end

    assign blk     = blk_q;
    assign bit_idx = bit_q;

    a_blk_range: assert property (
        @(posedge clk) disable iff (!rst_n) blk_q < BLK_W'(NUM_BLOCKS)
    );

endmodule

// File: rtl/sb_frame_config_loader.sv
// Serial bitstream to {address, data, enable} write strobes for the
// sb_1__3_ switch block; one setup cycle precedes every strobe.
module sb_frame_config_loader
    import sb_cfg_pkg::*;
(
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic              cfg_bit,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              enable,
    output logic [0:ADDR_W-1] address,
    output logic              data_out,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bits_written
);

    state_e            state_q, state_d;
    logic [0:ADDR_W-1] address_q, address_d;
    logic              data_q, data_d;
    logic [CNT_W-1:0]  bw_q, bw_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic              enable_q, enable_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cnt_clr, cnt_adv;
    logic [BLK_W-1:0]  blk;
    logic [BIT_W-1:0]  bit_idx;

    sb_cfg_addr_counter u_cnt (
        .clk     (prog_clk),
        .rst_n   (pReset_n),
        .clr     (cnt_clr),
        .adv     (cnt_adv),
        .blk     (blk),
        .bit_idx (bit_idx)
    );

    always_comb begin
        state_d   = state_q;
        address_d = address_q;
        data_d    = data_q;
        bw_d      = bw_q;
        cnt_clr   = 1'b0;
        cnt_adv   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_BIT;
                    cnt_clr = 1'b1;
                    bw_d    = '0;
                end
            end
            WAIT_BIT: begin
                if (cfg_valid && cfg_ready_q) begin
                    data_d    = cfg_bit;
                    address_d = cfg_addr(blk, bit_idx);
                    state_d   = SETUP;
                end
            end
            SETUP: state_d = STROBE;
            STROBE: begin
                cnt_adv = 1'b1;
                if (bw_q < CNT_W'(TOTAL_BITS)) begin
                    bw_d = bw_q + CNT_W'(1);
                end
                state_d = (bw_q == CNT_W'(TOTAL_BITS - 1)) ? DONE : WAIT_BIT;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // outputs are registered from the next state
        cfg_ready_d = (state_d == WAIT_BIT);
        enable_d    = (state_d == STROBE);
        busy_d      = (state_d inside {WAIT_BIT, SETUP, STROBE});
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q     <= IDLE;
            address_q   <= '0;
            data_q      <= 1'b0;
            bw_q        <= '0;
            cfg_ready_q <= 1'b0;
            enable_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            address_q   <= address_d;
            data_q      <= data_d;
            bw_q        <= bw_d;
            cfg_ready_q <= cfg_ready_d;
            enable_q    <= enable_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cfg_ready    = cfg_ready_q;
    assign enable       = enable_q;
    assign address      = address_q;
    assign data_out     = data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign bits_written = bw_q;

endmodule

// File: tb/tb_sb_frame_config_loader.sv
// Scoreboard bench for sb_frame_config_loader: driver queues expected
// writes from a block-table model, a negedge monitor checks strobes.
module tb_sb_frame_config_loader;

    localparam int BPB [15] = '{6, 6, 6, 2, 2, 2, 2, 2, 2, 2, 2, 2, 6, 6, 6};

    typedef struct packed {
        logic [6:0] a;
        logic       d;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cfg_bit = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic       enable;
    logic [0:6] address;
    logic       data_out;
    logic       busy;
    logic       done;
    logic [5:0] bits_written;

    int n_cmp = 0;
    int n_bad = 0;
    int enables = 0;
    int dones = 0;
    int ready_bad = 0;

    wr_t        exp_q [$];
    wr_t        log_cur [$];
    wr_t        log_a [$];
    logic [5:0] mem_img [15];
    logic [5:0] mem_a [15];
    logic [6:0] prev_a;
    logic       prev_d;
    logic       prev_ready;

    sb_frame_config_loader dut (
        .prog_clk     (clk),
        .pReset_n     (rst_n),
        .start        (start),
        .cfg_bit      (cfg_bit),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .enable       (enable),
        .address      (address),
        .data_out     (data_out),
        .busy         (busy),
        .done         (done),
        .bits_written (bits_written)
    );

    always #5 clk = ~clk;

    // k-th bit of the stream -> numeric address (address[0] is the MSB)
    function automatic logic [6:0] model_addr(input int k);
        int blk = 0;
        int r = k;
        while (r >= BPB[blk]) begin
            r -= BPB[blk];
            blk++;
        end
        return (BPB[blk] == 6) ? 7'(r * 16 + blk) : 7'(r * 64 + blk);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [6:0] av;
        wr_t        cur;
        wr_t        e;
        int         blk;
        av = address;
        if (!rst_n) begin
            prev_a     = '0;
            prev_d     = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (enable) begin
                cur = wr_t'{av, data_out};
                enables++;
                log_cur.push_back(cur);
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL strobe_unexpected: got %0h expected none", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        n_bad++;
                        $display("FAIL strobe_%0d: got a=%0h d=%0b expected a=%0h d=%0b",
                                 enables, cur.a, cur.d, e.a, e.d);
                    end
                end
                n_cmp++;
                if (prev_a !== av || prev_d !== data_out) begin
                    n_bad++;
                    $display("FAIL setup_stable_%0d: got a=%0h d=%0b before, a=%0h d=%0b during",
                             enables, prev_a, prev_d, av, data_out);
                end
                blk = int'(av[3:0]);
                if (blk < 15) begin
                    if (BPB[blk] == 6) mem_img[blk][av[6:4]] = data_out;
                    else mem_img[blk][av[6]] = data_out;
                end
                if (cfg_ready || prev_ready) ready_bad++;
            end
            if (done) begin
                dones++;
                if (cfg_ready) ready_bad++;
            end
            if (cfg_ready && !busy) ready_bad++;
            prev_a     = av;
            prev_d     = data_out;
            prev_ready = cfg_ready;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_bits(input bit bits[$], input bit gaps);
        for (int k = 0; k < bits.size(); k++) begin
            bit acc = 1'b0;
            int budget = 0;
            while (!acc) begin
                @(negedge clk);
                cfg_bit   = bits[k];
                cfg_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                acc = cfg_valid && cfg_ready;
                if (acc) exp_q.push_back(wr_t'{model_addr(k), bits[k]});
                budget++;
                if (!acc && budget > 200) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL handshake_timeout: got no accept for bit %0d expected accept", k);
                    cfg_valid = 1'b0;
                    return;
                end
            end
        end
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int t = 0;
        while (dones <= d0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", (dones > d0), 1);
    endtask

    task automatic clear_image();
        for (int b = 0; b < 15; b++) mem_img[b] = '0;
        log_cur.delete();
    endtask

    task automatic run_pass(input string tag, input bit bits[$], input bit gaps, input bit mid_start);
        int e0 = enables;
        int d0 = dones;
        clear_image();
        pulse_start();
        fork
            send_bits(bits, gaps);
            begin
                int t = 0;
                if (mid_start) begin
                    while (enables < e0 + 10 && t < 2000) begin
                        @(negedge clk);
                        t++;
                    end
                    pulse_start();
                end
            end
        join
        wait_done(d0);
        repeat (5) @(negedge clk);
        check({tag, "_enables"}, enables - e0, 54);
        check({tag, "_dones"}, dones - d0, 1);
        check({tag, "_bits_written"}, bits_written, 54);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        bit         alt [$];
        bit         rnd [$];
        logic [5:0] pat [15];
        int         diffs;
        int         e1;

        #500000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         alt [$];
        bit         rnd [$];
        bit         pbits [$];
        logic [5:0] pat [15];
        int         diffs;
        int         e1;

        for (int k = 0; k < 54; k++) alt.push_back(k % 2 == 0);

        repeat (3) @(negedge clk);
        check("reset_outputs",
              {cfg_ready, enable, address, data_out, busy, done, bits_written}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_outputs",
              {cfg_ready, enable, address, data_out, busy, done, bits_written}, 0);

        // gapless alternating pass
        run_pass("gapless", alt, 1'b0, 1'b0);
        log_a = log_cur;
        for (int b = 0; b < 15; b++) mem_a[b] = mem_img[b];
        check("gapless_log_size", log_a.size(), 54);
        if (log_a.size() > 20) begin
            check("strobe1", log_a[0], 8'h01);
            check("strobe7_blk", log_a[6].a[3:0], 1);
            check("strobe19_blk", log_a[18].a[3:0], 3);
            check("strobe19_addr0", log_a[18].a[6], 0);
            check("strobe21_blk", log_a[20].a[3:0], 4);
            check("strobe21_bit", log_a[20].a[6:4], 0);
        end

        // same stream with random valid gaps
        run_pass("gappy", alt, 1'b1, 1'b0);
        diffs = 0;
        if (log_cur.size() != log_a.size()) diffs++;
        for (int i = 0; i < log_cur.size() && i < log_a.size(); i++)
            if (log_cur[i] !== log_a[i]) diffs++;
        check("gappy_same_sequence", diffs, 0);
        diffs = 0;
        for (int b = 0; b < 15; b++) if (mem_img[b] !== mem_a[b]) diffs++;
        check("gappy_same_image", diffs, 0);

        // start pulsed again at write 10
        for (int k = 0; k < 54; k++) rnd.push_back(1'($urandom_range(0, 1)));
        run_pass("restart_ignored", rnd, 1'b1, 1'b1);

        // reset after write 20
        rnd.delete();
        for (int k = 0; k < 20; k++) rnd.push_back(1'($urandom_range(0, 1)));
        e1 = enables;
        pulse_start();
        send_bits(rnd, 1'b0);
        for (int t = 0; t < 100 && enables < e1 + 20; t++) @(negedge clk);
        check("pre_reset_writes", enables - e1, 20);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        e1 = enables;
        repeat (10) @(negedge clk);
        check("post_reset_outputs",
              {cfg_ready, enable, address, data_out, busy, done, bits_written}, 0);
        check("post_reset_no_strobe", enables - e1, 0);
        pulse_start();
        check("restart_bits_written", bits_written, 0);
        check("restart_busy", busy, 1);
        rnd.delete();
        for (int k = 0; k < 54; k++) rnd.push_back(1'($urandom_range(0, 1)));
        run_pass("after_reset", rnd, 1'b1, 1'b0);
        if (log_cur.size() > 0) check("after_reset_first_addr", log_cur[0].a, 0);

        // known memory image
        for (int b = 0; b < 15; b++)
            pat[b] = (BPB[b] == 6) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 3));
        pat[0] = 6'b101001;
        for (int b = 0; b < 15; b++)
            for (int i = 0; i < BPB[b]; i++) pbits.push_back(pat[b][i]);
        run_pass("image", pbits, 1'b1, 1'b0);
        for (int b = 0; b < 15; b++) check($sformatf("image_blk%0d", b), mem_img[b], pat[b]);

        check("scoreboard_drained", exp_q.size(), 0);
        check("cfg_ready_only_in_wait", ready_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
